chip_bus_arbiter: RTL and testbench
===================================

CHIP_BUS_ARBITER -- requirements
Module: chip_bus_arbiter

Interface
REQ-001 SHALL have parameter TURN_CYC, default 1, bus turnaround idle cycles between grants, legal range 1..15.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum grant length in cycles, used only when ARB_TIMEOUT_EN is defined, legal range 2..1023.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port _RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port REQ  input  3  level requests; bit n held high while requester n wants or uses the bus.
REQ-006 SHALL have port GNT  output  3  registered one-hot grant; all zero when no owner.
REQ-007 SHALL have port OWNER  output  2  index of current or last owner.
REQ-008 SHALL have port BUSY  output  1  high in GRANT and TURN states.
REQ-009 SHALL have port _BEN  output  1  active-low bus enable; low exactly when any GNT bit is high (NOR of GNT).
REQ-010 SHALL have port TOUT  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL implement states IDLE, GRANT, TURN with registered outputs only.
REQ-012 IDLE: any REQ bit high at an edge SHALL move the block to GRANT at that edge, with GNT, OWNER, BUSY and _BEN updated at the same edge (1-cycle request-to-grant latency).
REQ-013 Winner selection SHALL be round-robin: search starts at LAST+1 mod 3, and the first requester with a high, unmasked REQ wins; LAST SHALL be set to the winner index on every grant.
REQ-014 GRANT: GNT SHALL stay constant while REQ[OWNER] is high; other REQ bits SHALL have no effect.
REQ-015 GRANT with REQ[OWNER] low at an edge SHALL clear GNT, set _BEN high and enter TURN at that edge.
REQ-016 TURN SHALL last exactly TURN_CYC cycles, with GNT=0 and BUSY=1.
REQ-017 At the end of TURN, the block SHALL grant the round-robin winner directly if any unmasked REQ is high, giving a zero-cycle gap beyond TURN_CYC; otherwise it SHALL enter IDLE with BUSY=0.
REQ-018 Simultaneous requests SHALL be resolved only by REQ-013; the grant SHALL never be more than one-hot.
REQ-019 A requester deasserting REQ before it is granted SHALL simply not be selected; no request state is latched.
REQ-020 OWNER SHALL retain its last value in IDLE and TURN.

Reset
REQ-021 _RST low SHALL immediately force state IDLE, GNT=000, OWNER=00, BUSY=0, _BEN=1, TOUT=0, LAST=2 (requester 0 first), timeout counter 0, mask clear.
REQ-022 Reset asserted mid-grant SHALL drop GNT without a TURN phase; the first grant after release SHALL follow REQ-012.

Configuration
REQ-023 With macro ARB_TIMEOUT_EN defined, a counter SHALL start at 0 on each grant and increment each GRANT cycle.
REQ-024 With ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT-1 and another REQ bit is high, the block SHALL force the REQ-015 transition, pulse TOUT for one cycle, and mask the evicted requester until its REQ goes low.
REQ-025 With ARB_TIMEOUT_EN defined, a lone requester SHALL never be evicted; its counter SHALL saturate.
REQ-026 Without ARB_TIMEOUT_EN, there SHALL be no counter or mask logic, TOUT SHALL be constant 0, and grants SHALL be unbounded.

Verification
REQ-027 Reset release, REQ=001 at cycle 0 -> GNT=001, OWNER=0, _BEN=0 after edge 1; REQ=000 -> GNT=000 next edge, BUSY=1 for 1 cycle, then IDLE.
REQ-028 REQ=111 held, each owner drops its bit for 1 cycle after 3 grant cycles -> grant order 0,1,2,0 with one TURN cycle between grants.
REQ-029 TURN_CYC=3, owner 1 releases while REQ[2]=1 -> GNT=000 for exactly 3 cycles, then GNT=100.
REQ-030 _RST pulsed low during GNT=010 -> GNT=000, _BEN=1 asynchronously; after release, REQ=110 -> GNT=010 (LAST reset to 2).
REQ-031 ARB_TIMEOUT_EN defined, TIMEOUT=8, REQ=011 held, 0 granted -> GNT=000 and TOUT=1 after 8 grant cycles, then GNT=010; 0 not regranted until REQ[0] toggles low.
REQ-032 ARB_TIMEOUT_EN defined, REQ=001 held for 100 cycles -> GNT=001 throughout, TOUT never 1.

Source files
------------

// File: rtl/chip_bus_arbiter.sv
// chip_bus_arbiter: three-requester round-robin bus arbiter with bus turnaround.
// The optional forced-release feature is built only when macro ARB_TIMEOUT_EN is defined.
//
// Parameters:
//   TURN_CYC : idle turnaround cycles between grants (1..15)
//   TIMEOUT  : maximum grant length in cycles when ARB_TIMEOUT_EN is defined (2..1023)
//
// Ports:
//   CLK   : clock; all state changes on the rising edge
//   _RST  : asynchronous active-low reset
//   REQ   : level requests; bit n high while requester n wants or holds the bus
//   GNT   : registered one-hot grant; zero when there is no owner
//   OWNER : index of the current or last owner
//   BUSY  : high while in GRANT or TURN
//   _BEN  : active-low bus enable, low exactly when a GNT bit is high
//   TOUT  : one-cycle pulse when an owner is forcibly released
module chip_bus_arbiter #(
   parameter int unsigned TURN_CYC = 1,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic       CLK,
   input  logic       _RST,
   input  logic [2:0] REQ,
   output logic [2:0] GNT,
   output logic [1:0] OWNER,
   output logic       BUSY,
   output logic       _BEN,
   output logic       TOUT
);

   localparam int unsigned REQ_W  = 3;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned TURN_W = 4;
   localparam int unsigned CNT_W  = 10;

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   // Elaboration-time guard on parameter ranges
   if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn_cyc
      $error("chip_bus_arbiter: TURN_CYC out of range 1..15");
   end
   if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
      $error("chip_bus_arbiter: TIMEOUT out of range 2..1023");
   end

   state_t              state, state_d;
   logic [REQ_W-1:0]    gnt_d;
   logic [IDX_W-1:0]    owner_d, last, last_d, win;
   logic [TURN_W-1:0]   turn_cnt, turn_d;
   logic                busy_d, win_vld, grant_now, release_now, evict;
   logic [REQ_W-1:0]    elig;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0]    cnt;
   logic [REQ_W-1:0]    mask;

   assign elig  = REQ & ~mask;
   // Evict only when someone else could actually take the bus
   assign evict = (state == GRANT) && REQ[OWNER] &&
                  (cnt == CNT_W'(TIMEOUT - 1)) && (|(elig & ~GNT));

   // Grant-length counter, eviction mask and timeout pulse
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         cnt  <= '0;
         mask <= '0;
         TOUT <= 1'b0;
      end else begin
         TOUT <= evict;
         // A masked requester is released once it drops its request
         mask <= (mask & REQ) | (evict ? GNT : '0);
         if (grant_now)
            cnt <= '0;
         else if (state == GRANT && cnt != CNT_W'(TIMEOUT - 1))
            cnt <= cnt + 1'b1;
      end
   end
`else
   assign elig  = REQ;
   assign evict = 1'b0;
   assign TOUT  = 1'b0;
`endif

   // Round-robin pick: search starts at last+1 mod 3
   always_comb begin
      win_vld = |elig;
      win     = '0;
      case (last)
         2'd0:    win = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
         2'd1:    win = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
         default: win = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      gnt_d       = GNT;
      owner_d     = OWNER;
      last_d      = last;
      busy_d      = BUSY;
      turn_d      = turn_cnt;
      grant_now   = 1'b0;
      release_now = 1'b0;

      case (state)
         IDLE: begin
            busy_d = 1'b0;
            if (win_vld)
               grant_now = 1'b1;
         end
         GRANT: begin
            if (!REQ[OWNER] || evict)
               release_now = 1'b1;
         end
         TURN: begin
            if (turn_cnt == TURN_W'(TURN_CYC - 1)) begin
               if (win_vld) begin
                  grant_now = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               turn_d = turn_cnt + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase

      if (grant_now) begin
         state_d = GRANT;
         gnt_d   = REQ_W'(1) << win;
         owner_d = win;
         last_d  = win;
         busy_d  = 1'b1;
      end

      if (release_now) begin
         state_d = TURN;
         gnt_d   = '0;
         busy_d  = 1'b1;
         turn_d  = '0;
      end
   end

   // State and registered outputs
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         state    <= IDLE;
         GNT      <= '0;
         OWNER    <= '0;
         BUSY     <= 1'b0;
         _BEN     <= 1'b1;
         last     <= 2'd2;
         turn_cnt <= '0;
      end else begin
         state    <= state_d;
         GNT      <= gnt_d;
         OWNER    <= owner_d;
         BUSY     <= busy_d;
         _BEN     <= ~|gnt_d;
         last     <= last_d;
         turn_cnt <= turn_d;
      end
   end

endmodule

// File: tb/tb_chip_bus_arbiter.sv
// tb_chip_bus_arbiter: directed checks of chip_bus_arbiter.
// Instance a uses TURN_CYC=1, TIMEOUT=8; instance b uses TURN_CYC=3.
// Observed state is packed as {GNT[2:0], OWNER[1:0], BUSY, _BEN, TOUT}.
module tb_chip_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req_a, req_b;
   logic [2:0] gnt_a, gnt_b;
   logic [1:0] owner_a, owner_b;
   logic       busy_a, busy_b, ben_a, ben_b, tout_a, tout_b;
   logic [7:0] st_a, st_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   chip_bus_arbiter #(.TURN_CYC(1), .TIMEOUT(8)) u_a (
      .CLK(clk), ._RST(rst_n), .REQ(req_a), .GNT(gnt_a), .OWNER(owner_a),
      .BUSY(busy_a), ._BEN(ben_a), .TOUT(tout_a)
   );

   chip_bus_arbiter #(.TURN_CYC(3)) u_b (
      .CLK(clk), ._RST(rst_n), .REQ(req_b), .GNT(gnt_b), .OWNER(owner_b),
      .BUSY(busy_b), ._BEN(ben_b), .TOUT(tout_b)
   );

   assign st_a = {gnt_a, owner_a, busy_a, ben_a, tout_a};
   assign st_b = {gnt_b, owner_b, busy_b, ben_b, tout_b};

   // Expected packed states
   localparam logic [7:0] S_RST  = 8'b000_00_010;
   localparam logic [7:0] S_G0   = 8'b001_00_100;
   localparam logic [7:0] S_G1   = 8'b010_01_100;
   localparam logic [7:0] S_G2   = 8'b100_10_100;
   localparam logic [7:0] S_T0   = 8'b000_00_110;
   localparam logic [7:0] S_T1   = 8'b000_01_110;
   localparam logic [7:0] S_T2   = 8'b000_10_110;
   localparam logic [7:0] S_I0   = 8'b000_00_010;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Apply requests for the next rising edge, then check after it
   task automatic step_a(input logic [2:0] r, input logic [7:0] exp, input string tag);
      req_a = r;
      @(negedge clk);
      check(tag, st_a, exp);
   endtask

   task automatic step_b(input logic [2:0] r, input logic [7:0] exp, input string tag);
      req_b = r;
      @(negedge clk);
      check(tag, st_b, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_a = '0;
      req_b = '0;
      repeat (2) @(negedge clk);
      check("reset_a", st_a, S_RST);
      check("reset_b", st_b, S_RST);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = '0;
      req_b = '0;

      // Single request, release, one turnaround cycle, back to idle
      do_reset();
      step_a(3'b001, S_G0,  "single_grant");
      step_a(3'b000, S_T0,  "single_turn");
      step_a(3'b000, S_I0,  "single_idle");

      // Rotating ownership with all three requesting
      do_reset();
      step_a(3'b111, S_G0, "rr_g0_c1");
      step_a(3'b111, S_G0, "rr_g0_c2");
      step_a(3'b111, S_G0, "rr_g0_c3");
      step_a(3'b110, S_T0, "rr_turn0");
      step_a(3'b111, S_G1, "rr_g1_c1");
      step_a(3'b111, S_G1, "rr_g1_c2");
      step_a(3'b111, S_G1, "rr_g1_c3");
      step_a(3'b101, S_T1, "rr_turn1");
      step_a(3'b111, S_G2, "rr_g2_c1");
      step_a(3'b111, S_G2, "rr_g2_c2");
      step_a(3'b111, S_G2, "rr_g2_c3");
      step_a(3'b011, S_T2, "rr_turn2");
      step_a(3'b111, S_G0, "rr_g0_again");
      // Requester 2 withdraws before it is served
      step_a(3'b100, S_T0, "withdraw_turn");
      step_a(3'b000, S_I0, "withdraw_idle");

      // Asynchronous reset in the middle of a grant
      do_reset();
      step_a(3'b110, S_G1, "pre_rst_g1");
      #2 rst_n = 1'b0;
      #1 check("async_rst", st_a, S_RST);
      @(negedge clk);
      rst_n = 1'b1;
      step_a(3'b110, S_G1, "post_rst_g1");

      // Three-cycle turnaround
      do_reset();
      step_b(3'b010, S_G1, "turn3_g1");
      step_b(3'b110, S_G1, "turn3_hold");
      step_b(3'b100, S_T1, "turn3_t1");
      step_b(3'b100, S_T1, "turn3_t2");
      step_b(3'b100, S_T1, "turn3_t3");
      step_b(3'b100, S_G2, "turn3_g2");

`ifdef ARB_TIMEOUT_EN
      // Forced release after TIMEOUT grant cycles with a competitor waiting
      do_reset();
      for (int i = 0; i < 8; i++)
         step_a(3'b011, S_G0, $sformatf("tmo_g0_c%0d", i + 1));
      step_a(3'b011, 8'b000_00_111, "tmo_evict");
      step_a(3'b011, S_G1, "tmo_g1");
      // Only a masked competitor remains: no further eviction
      for (int i = 0; i < 12; i++)
         step_a(3'b011, S_G1, $sformatf("tmo_g1_hold%0d", i));
      step_a(3'b001, S_T1,         "tmo_rel1");
      step_a(3'b001, 8'b000_01_010, "tmo_masked_idle");
      step_a(3'b000, 8'b000_01_010, "tmo_unmask");
      step_a(3'b001, S_G0,         "tmo_regrant0");

      // Lone requester is never evicted
      do_reset();
      for (int i = 0; i < 100; i++)
         step_a(3'b001, S_G0, $sformatf("lone_c%0d", i));
`else
      // Grants are unbounded and TOUT stays low
      do_reset();
      for (int i = 0; i < 20; i++)
         step_a(3'b011, S_G0, $sformatf("unbounded_c%0d", i));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
